// File: rtl/bp_fpga_host_pkg.sv
// Shared FPGA-host NBF definitions: packet layout, opcodes and size helpers.
// Used by the TX arbiter, the round-robin arbiter and the RX deserializer.
package bp_fpga_host_pkg;

  localparam int unsigned nbf_opcode_width_gp = 8;
  localparam int unsigned nbf_addr_width_gp   = 40;
  localparam int unsigned nbf_data_width_gp   = 64;

  // NBF packet layout for a given address width; opcode sits at the LSB
  `define BP_FPGA_HOST_NBF_DECLARE(addr_w) \
    typedef struct packed { \
      logic [63:0]       data; \
      logic [addr_w-1:0] addr; \
      logic [7:0]        opcode; \
    } bp_fpga_host_nbf_s

  // Default-width packet
  typedef struct packed {
    logic [nbf_data_width_gp-1:0]   data;
    logic [nbf_addr_width_gp-1:0]   addr;
    logic [nbf_opcode_width_gp-1:0] opcode;
  } bp_fpga_host_nbf_default_s;

  typedef enum logic [7:0] {
    e_nbf_write_4  = 8'h02,
    e_nbf_write_8  = 8'h03,
    e_nbf_read_4   = 8'h12,
    e_nbf_read_8   = 8'h13,
    e_nbf_putch    = 8'h80,
    e_nbf_fence    = 8'hFE,
    e_nbf_finish   = 8'hFF
  } bp_fpga_host_nbf_opcode_e;

  // Whole bytes in one serialized NBF packet
  function automatic int unsigned nbf_pkt_bytes(input int unsigned op_w,
                                                input int unsigned addr_w,
                                                input int unsigned data_w);
    return (op_w + addr_w + data_w) / 8;
  endfunction

  // Index width that stays at least one bit for a single element
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bp_fpga_host_rr_arb.sv
// Combinational round-robin arbiter: first requester at or after ptr_i wins.
// Ports: req_i (requests), ptr_i (current priority pointer), grant_o (one-hot),
//        id_o (winner index), v_o (any request), ptr_next_o (winner+1 mod els_p).
module bp_fpga_host_rr_arb
  import bp_fpga_host_pkg::*;
#(
  parameter  int unsigned els_p   = 2,
  localparam int unsigned id_w_lp = id_width(els_p)
) (
  input  logic [els_p-1:0]   req_i,
  input  logic [id_w_lp-1:0] ptr_i,
  output logic [els_p-1:0]   grant_o,
  output logic [id_w_lp-1:0] id_o,
  output logic               v_o,
  output logic [id_w_lp-1:0] ptr_next_o
);

  logic [id_w_lp-1:0]              w_dist [els_p];
  logic [id_w_lp-1:0][els_p-1:0]   w_idbits;

  // Distance of each source from the pointer; nearest requester wins
  for (genvar k = 0; k < els_p; k++) begin : g_src
    logic [els_p-1:0] w_closer;
    assign w_dist[k] = id_w_lp'((32'(k) + els_p - 32'(ptr_i)) % els_p);
    for (genvar j = 0; j < els_p; j++) begin : g_cmp
      assign w_closer[j] = req_i[j] && (w_dist[j] < w_dist[k]);
    end
    assign grant_o[k] = req_i[k] && !(|w_closer);
  end

  // One-hot to index encode
  for (genvar b = 0; b < id_w_lp; b++) begin : g_idb
    for (genvar k = 0; k < els_p; k++) begin : g_src
      assign w_idbits[b][k] = grant_o[k] && (((k >> b) % 2) == 1);
    end
    assign id_o[b] = |w_idbits[b];
  end

  assign v_o        = |req_i;
  assign ptr_next_o = (32'(id_o) == els_p - 1) ? '0 : id_o + 1'b1;

endmodule

// File: rtl/bp_fpga_host_tx_arbiter.sv
// Grants whole NBF packets round-robin and serializes them LSB byte first.
// Ports: clk_i/reset_i (async active-high), pkt_i/pkt_v_i/pkt_yumi_o (packet
//        sources, valid->yumi), byte_o/byte_v_o/byte_ready_and_i (UART TX),
//        grant_id_o (source being sent), busy_o (high while sending).
module bp_fpga_host_tx_arbiter
  import bp_fpga_host_pkg::*;
#(
  parameter  int unsigned els_p              = 2,
  parameter  int unsigned nbf_addr_width_p   = 40,
  parameter  int unsigned nbf_data_width_p   = 64,
  parameter  int unsigned nbf_opcode_width_p = 8,
  localparam int unsigned pkt_bytes_lp = nbf_pkt_bytes(nbf_opcode_width_p,
                                                       nbf_addr_width_p,
                                                       nbf_data_width_p),
  localparam int unsigned pkt_w_lp     = 8 * pkt_bytes_lp,
  localparam int unsigned id_w_lp      = id_width(els_p),
  localparam int unsigned cnt_w_lp     = (pkt_bytes_lp > 1) ? $clog2(pkt_bytes_lp) : 1
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [els_p*pkt_w_lp-1:0] pkt_i,
  input  logic [els_p-1:0]          pkt_v_i,
  output logic [els_p-1:0]          pkt_yumi_o,
  output logic [7:0]                byte_o,
  output logic                      byte_v_o,
  input  logic                      byte_ready_and_i,
  output logic [id_w_lp-1:0]        grant_id_o,
  output logic                      busy_o
);

  typedef enum logic {e_idle, e_send} state_e;

  state_e              r_state, w_state_n;
  logic [id_w_lp-1:0]  r_ptr, w_ptr_n;
  logic [id_w_lp-1:0]  r_grant_id, w_grant_id_n;
  logic [cnt_w_lp-1:0] r_cnt, w_cnt_n;
  logic [pkt_w_lp-1:0] r_shift, w_shift_n;
  logic [pkt_w_lp-1:0] w_pkt_sel;
  logic [els_p-1:0]    w_arb_grant;
  logic [id_w_lp-1:0]  w_arb_id, w_arb_ptr_next;
  logic                w_arb_v;

  bp_fpga_host_rr_arb #(.els_p(els_p)) u_rr_arb (
    .req_i      (pkt_v_i),
    .ptr_i      (r_ptr),
    .grant_o    (w_arb_grant),
    .id_o       (w_arb_id),
    .v_o        (w_arb_v),
    .ptr_next_o (w_arb_ptr_next)
  );

  // AND-OR select of the granted source's packet
  for (genvar b = 0; b < pkt_w_lp; b++) begin : g_bit
    logic [els_p-1:0] w_col;
    for (genvar k = 0; k < els_p; k++) begin : g_src
      assign w_col[k] = pkt_i[k*pkt_w_lp + b] & w_arb_grant[k];
    end
    assign w_pkt_sel[b] = |w_col;
  end

  // State and datapath registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state    <= e_idle;
      r_ptr      <= '0;
      r_grant_id <= '0;
      r_cnt      <= '0;
      r_shift    <= '0;
    end else begin
      r_state    <= w_state_n;
      r_ptr      <= w_ptr_n;
      r_grant_id <= w_grant_id_n;
      r_cnt      <= w_cnt_n;
      r_shift    <= w_shift_n;
    end
  end

  // Next state and outputs; yumi is combinational on pkt_v_i in IDLE only
  always_comb begin
    w_state_n    = r_state;
    w_ptr_n      = r_ptr;
    w_grant_id_n = r_grant_id;
    w_cnt_n      = r_cnt;
    w_shift_n    = r_shift;
    pkt_yumi_o   = '0;
    byte_v_o     = 1'b0;
    busy_o       = 1'b0;
    unique case (r_state)
      e_idle: begin
        if (w_arb_v && !reset_i) begin
          pkt_yumi_o   = w_arb_grant;
          w_shift_n    = w_pkt_sel;
          w_grant_id_n = w_arb_id;
          w_cnt_n      = '0;
          w_ptr_n      = w_arb_ptr_next;
          w_state_n    = e_send;
        end
      end
      e_send: begin
        byte_v_o = 1'b1;
        busy_o   = 1'b1;
        if (byte_ready_and_i) begin
          w_shift_n = r_shift >> 8;
          w_cnt_n   = r_cnt + 1'b1;
          if (r_cnt == cnt_w_lp'(pkt_bytes_lp - 1)) begin
            w_state_n = e_idle;
          end
        end
      end
      default: w_state_n = e_idle;
    endcase
  end

  assign byte_o     = r_shift[7:0];
  assign grant_id_o = r_grant_id;

endmodule
